// File: rtl/dspl_arbiter.sv
// dspl_arbiter: shares the 8-digit multiplexed display driver between two
// requesters (A and B). Round-robin grant with minimum/maximum hold times,
// optional whole-frame blinking, and a registered frame path to d1..d8.
// Each digit word is {en, glyph[3:0], dp_n}; d1 is the rightmost digit.
module dspl_arbiter #(
  parameter int MS_COUNT = 100000,
  parameter int HOLD_MS  = 500,
  parameter int MAX_MS   = 3000,
  parameter int BLINK_MS = 250
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_a,
  input  logic        blink_a,
  input  logic [47:0] frame_a,
  input  logic        req_b,
  input  logic        blink_b,
  input  logic [47:0] frame_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic [5:0]  d1,
  output logic [5:0]  d2,
  output logic [5:0]  d3,
  output logic [5:0]  d4,
  output logic [5:0]  d5,
  output logic [5:0]  d6,
  output logic [5:0]  d7,
  output logic [5:0]  d8
);

  localparam int MS_W = (MS_COUNT > 1) ? $clog2(MS_COUNT) : 1;
  localparam int HC_W = $clog2(MAX_MS + 1);
  localparam int BC_W = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

  localparam logic [MS_W-1:0] MS_LAST = MS_W'(MS_COUNT - 1);
  localparam logic [HC_W-1:0] HOLD_V  = HC_W'(HOLD_MS);
  localparam logic [HC_W-1:0] MAX_V   = HC_W'(MAX_MS);
  localparam logic [BC_W-1:0] BL_LAST = BC_W'(BLINK_MS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW_A = 2'd1,
    SHOW_B = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              grant;

  logic [MS_W-1:0]   ms_cnt_q, ms_cnt_d;
  logic              ms_tick;
  logic [HC_W-1:0]   hold_q, hold_d;
  logic [BC_W-1:0]   bcnt_q, bcnt_d;
  logic              phase_q, phase_d;
  logic              last_b_q, last_b_d;

  logic              own_b;
  logic              own_req;
  logic              own_blink;
  logic [47:0]       own_frame;
  logic [47:0]       shown;
  logic [47:0]       frz_q, frz_d;
  logic [47:0]       dout_q, dout_d;
  logic              gnt_a_q, gnt_a_d;
  logic              gnt_b_q, gnt_b_d;

  // Clear the enable bit of every digit: the dark half of a blink period.
  function automatic logic [47:0] blank_en(input logic [47:0] f);
    logic [47:0] r;
    r = f;
    for (int i = 0; i < 8; i++) begin
      r[i*6+5] = 1'b0;
    end
    return r;
  endfunction

  // Free-running millisecond timebase; ms_tick marks the wrap cycle.
  always_comb begin
    ms_tick  = (ms_cnt_q == MS_LAST);
    ms_cnt_d = ms_tick ? '0 : ms_cnt_q + 1'b1;
  end

  // Ownership decision: round-robin on ties, min-hold release, max-hold pre-emption.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_a && (!req_b || last_b_q)) begin
          state_d = SHOW_A;
          grant   = 1'b1;
        end else if (req_b) begin
          state_d = SHOW_B;
          grant   = 1'b1;
        end
      end
      SHOW_A: begin
        if (req_b && (hold_q >= MAX_V)) begin
          state_d = SHOW_B;
          grant   = 1'b1;
        end else if (!req_a && (hold_q >= HOLD_V)) begin
          state_d = req_b ? SHOW_B : IDLE;
          grant   = req_b;
        end
      end
      SHOW_B: begin
        if (req_a && (hold_q >= MAX_V)) begin
          state_d = SHOW_A;
          grant   = 1'b1;
        end else if (!req_b && (hold_q >= HOLD_V)) begin
          state_d = req_a ? SHOW_A : IDLE;
          grant   = req_a;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Hold time, blink phase and last-served pointer restart on every grant.
  always_comb begin
    hold_d   = hold_q;
    bcnt_d   = bcnt_q;
    phase_d  = phase_q;
    last_b_d = last_b_q;
    if (grant) begin
      hold_d   = '0;
      bcnt_d   = '0;
      phase_d  = 1'b1;
      last_b_d = (state_d == SHOW_B);
    end else if (ms_tick) begin
      if (hold_q < MAX_V) begin
        hold_d = hold_q + 1'b1;
      end
      if (bcnt_q == BL_LAST) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  // Display path: owner's live frame while it requests, frozen copy otherwise.
  always_comb begin
    own_b     = (state_q == SHOW_B);
    own_req   = own_b ? req_b   : req_a;
    own_blink = own_b ? blink_b : blink_a;
    own_frame = own_b ? frame_b : frame_a;
    shown     = own_req ? own_frame : frz_q;

    dout_d = '0;
    if (state_q != IDLE) begin
      dout_d = (own_blink && !phase_q) ? blank_en(shown) : shown;
    end

    frz_d = frz_q;
    if (grant) begin
      frz_d = (state_d == SHOW_B) ? frame_b : frame_a;
    end else if ((state_q != IDLE) && own_req) begin
      frz_d = own_frame;
    end

    gnt_a_d = (state_q == SHOW_A);
    gnt_b_d = (state_q == SHOW_B);
  end

  // Ownership state and its timers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ms_cnt_q <= '0;
      hold_q   <= '0;
      bcnt_q   <= '0;
      phase_q  <= 1'b0;
      last_b_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      ms_cnt_q <= ms_cnt_d;
      hold_q   <= hold_d;
      bcnt_q   <= bcnt_d;
      phase_q  <= phase_d;
      last_b_q <= last_b_d;
    end
  end

  // Registered grants, frozen frame and digit words.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      frz_q   <= '0;
      dout_q  <= '0;
    end else begin
      gnt_a_q <= gnt_a_d;
      gnt_b_q <= gnt_b_d;
      frz_q   <= frz_d;
      dout_q  <= dout_d;
    end
  end

  assign gnt_a = gnt_a_q;
  assign gnt_b = gnt_b_q;
  assign d1    = dout_q[5:0];
  assign d2    = dout_q[11:6];
  assign d3    = dout_q[17:12];
  assign d4    = dout_q[23:18];
  assign d5    = dout_q[29:24];
  assign d6    = dout_q[35:30];
  assign d7    = dout_q[41:36];
  assign d8    = dout_q[47:42];

endmodule
